// File: rtl/core_frame_receiver.sv
// Core-side receiver for the scheduler->core program link.
// It decodes the 16-word header frame and checks whether this core is selected.
// For a selected core it loads r0 and writes the instruction frames into local
// instruction memory, then signals that the program is loaded.
module core_frame_receiver #(
    parameter int CORE_ID     = 0,
    parameter int CORE_NUM    = 16,
    parameter int INSTR_SIZE  = 16,
    parameter int FRAME_WORDS = 16,
    parameter int R0_DEPTH    = 8,
    parameter int IMEM_AW     = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_being_sent,
    input  logic                  bus_valid,
    input  logic [INSTR_SIZE-1:0] bus_data,
    input  logic                  exec_done,
    output logic                  core_ready,
    output logic                  core_reading,
    output logic                  imem_we,
    output logic [IMEM_AW-1:0]    imem_addr,
    output logic [INSTR_SIZE-1:0] imem_wdata,
    output logic                  r0_we,
    output logic [INSTR_SIZE-1:0] r0_data,
    output logic [1:0]            fence,
    output logic                  prog_valid,
    output logic [IMEM_AW:0]      instr_count,
    output logic                  err_abort
);

    localparam int WW    = $clog2(FRAME_WORDS);
    localparam int CNT_W = IMEM_AW + 1;

    // Header word positions, and this core's bit within the core/r0 masks
    localparam logic [WW-1:0] LAST_WORD   = WW'(FRAME_WORDS - 1);
    localparam logic [WW-1:0] MASK_WORD   = WW'(1);
    localparam logic [WW-1:0] R0MASK_WORD = WW'(2);
    localparam logic [WW-1:0] R0_WORD     = WW'(FRAME_WORDS - R0_DEPTH + (CORE_ID % R0_DEPTH));
    localparam int            SEL_BIT     = CORE_ID % CORE_NUM;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR    = 3'd1,
        INSTR  = 3'd2,
        SKIP   = 3'd3,
        DONE   = 3'd4,
        LOADED = 3'd5
    } state_t;

    state_t state_reg, state_next;

    logic                  accept;
    logic [WW-1:0]         word_reg;
    logic [1:0]            frame_reg;
    logic [1:0]            if_num_reg;
    logic [1:0]            hdr_fence_reg;
    logic                  selected_reg;
    logic                  r0_sel_reg;
    logic [CNT_W-1:0]      instr_idx;
    logic [CNT_W-1:0]      instr_total;

    logic                  imem_we_reg;
    logic [IMEM_AW-1:0]    imem_addr_reg;
    logic [INSTR_SIZE-1:0] imem_wdata_reg;
    logic                  r0_we_reg;
    logic [INSTR_SIZE-1:0] r0_data_reg;
    logic [1:0]            fence_reg;
    logic                  prog_valid_reg;
    logic [CNT_W-1:0]      instr_count_reg;
    logic                  err_abort_reg;

    assign accept      = frame_being_sent && bus_valid;
    // Position of the current word within the instruction stream (frames after the header)
    assign instr_idx   = CNT_W'(frame_reg) * CNT_W'(FRAME_WORDS) + CNT_W'(word_reg);
    assign instr_total = CNT_W'(if_num_reg) * CNT_W'(FRAME_WORDS);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        state_next   = state_reg;
        core_ready   = 1'b1;
        core_reading = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = HDR;
                end
            end
            HDR: begin
                core_ready   = !selected_reg;
                core_reading = selected_reg;
                if (!frame_being_sent) begin
                    state_next = IDLE;
                end else if (accept) begin
                    if (word_reg == MASK_WORD && !bus_data[SEL_BIT]) begin
                        state_next = SKIP;
                    end else if (word_reg == LAST_WORD) begin
                        state_next = (if_num_reg == 2'd0) ? DONE : INSTR;
                    end
                end
            end
            INSTR: begin
                core_ready   = 1'b0;
                core_reading = 1'b1;
                if (!frame_being_sent) begin
                    state_next = IDLE;
                end else if (accept && instr_idx == instr_total - CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            SKIP: begin
                // The header counts as frame 0 here, so the last frame index equals if_num
                if (!frame_being_sent) begin
                    state_next = IDLE;
                end else if (accept && word_reg == LAST_WORD && frame_reg == if_num_reg) begin
                    state_next = IDLE;
                end
            end
            DONE: begin
                core_ready = 1'b0;
                state_next = LOADED;
            end
            LOADED: begin
                core_ready = 1'b0;
                if (exec_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Word/frame counters, header fields and registered memory/r0 writes
    always_ff @(posedge clk) begin
        if (reset) begin
            word_reg        <= '0;
            frame_reg       <= '0;
            if_num_reg      <= '0;
            hdr_fence_reg   <= '0;
            selected_reg    <= 1'b0;
            r0_sel_reg      <= 1'b0;
            imem_we_reg     <= 1'b0;
            imem_addr_reg   <= '0;
            imem_wdata_reg  <= '0;
            r0_we_reg       <= 1'b0;
            r0_data_reg     <= '0;
            fence_reg       <= '0;
            prog_valid_reg  <= 1'b0;
            instr_count_reg <= '0;
            err_abort_reg   <= 1'b0;
        end else begin
            imem_we_reg    <= 1'b0;
            r0_we_reg      <= 1'b0;
            prog_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if_num_reg    <= bus_data[1:0];
                        hdr_fence_reg <= bus_data[3:2];
                        word_reg      <= WW'(1);
                        frame_reg     <= '0;
                        selected_reg  <= 1'b0;
                        r0_sel_reg    <= 1'b0;
                    end
                end
                HDR: begin
                    if (!frame_being_sent) begin
                        err_abort_reg <= 1'b1;
                    end else if (accept) begin
                        word_reg <= (word_reg == LAST_WORD) ? '0 : word_reg + WW'(1);
                        if (word_reg == MASK_WORD && bus_data[SEL_BIT]) begin
                            selected_reg <= 1'b1;
                            fence_reg    <= hdr_fence_reg;
                        end
                        if (word_reg == R0MASK_WORD) begin
                            r0_sel_reg <= bus_data[SEL_BIT];
                        end
                        if (word_reg == R0_WORD && r0_sel_reg) begin
                            r0_we_reg   <= 1'b1;
                            r0_data_reg <= bus_data;
                        end
                    end
                end
                INSTR: begin
                    if (!frame_being_sent) begin
                        err_abort_reg <= 1'b1;
                    end else if (accept) begin
                        imem_we_reg    <= 1'b1;
                        imem_addr_reg  <= instr_idx[IMEM_AW-1:0];
                        imem_wdata_reg <= bus_data;
                        word_reg       <= (word_reg == LAST_WORD) ? '0 : word_reg + WW'(1);
                        if (word_reg == LAST_WORD) begin
                            frame_reg <= frame_reg + 2'd1;
                        end
                    end
                end
                SKIP: begin
                    if (accept) begin
                        word_reg <= (word_reg == LAST_WORD) ? '0 : word_reg + WW'(1);
                        if (word_reg == LAST_WORD) begin
                            frame_reg <= frame_reg + 2'd1;
                        end
                    end
                end
                DONE: begin
                    prog_valid_reg  <= 1'b1;
                    instr_count_reg <= instr_total;
                end
                default: begin
                end
            endcase
        end
    end

    assign imem_we     = imem_we_reg;
    assign imem_addr   = imem_addr_reg;
    assign imem_wdata  = imem_wdata_reg;
    assign r0_we       = r0_we_reg;
    assign r0_data     = r0_data_reg;
    assign fence       = fence_reg;
    assign prog_valid  = prog_valid_reg;
    assign instr_count = instr_count_reg;
    assign err_abort   = err_abort_reg;

endmodule

// File: tb/tb_core_frame_receiver.sv
// Bench for core_frame_receiver: three receivers (core ids 0, 8 and 4) share one bus
// and are driven with directed program streams.
module tb_core_frame_receiver;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_being_sent = 1'b0;
    logic        bus_valid = 1'b0;
    logic [15:0] bus_data = 16'h0000;
    logic        exec_done = 1'b0;

    logic        core_ready   [N];
    logic        core_reading [N];
    logic        imem_we      [N];
    logic [5:0]  imem_addr    [N];
    logic [15:0] imem_wdata   [N];
    logic        r0_we        [N];
    logic [15:0] r0_data      [N];
    logic [1:0]  fence        [N];
    logic        prog_valid   [N];
    logic [6:0]  instr_count  [N];
    logic        err_abort    [N];

    always #5 clk = ~clk;

    // index 0 -> core 0, index 1 -> core 8, index 2 -> core 4
    core_frame_receiver #(.CORE_ID(0)) u_core0 (
        .clk(clk), .reset(reset), .frame_being_sent(frame_being_sent), .bus_valid(bus_valid),
        .bus_data(bus_data), .exec_done(exec_done), .core_ready(core_ready[0]),
        .core_reading(core_reading[0]), .imem_we(imem_we[0]), .imem_addr(imem_addr[0]),
        .imem_wdata(imem_wdata[0]), .r0_we(r0_we[0]), .r0_data(r0_data[0]), .fence(fence[0]),
        .prog_valid(prog_valid[0]), .instr_count(instr_count[0]), .err_abort(err_abort[0]));

    core_frame_receiver #(.CORE_ID(8)) u_core8 (
        .clk(clk), .reset(reset), .frame_being_sent(frame_being_sent), .bus_valid(bus_valid),
        .bus_data(bus_data), .exec_done(exec_done), .core_ready(core_ready[1]),
        .core_reading(core_reading[1]), .imem_we(imem_we[1]), .imem_addr(imem_addr[1]),
        .imem_wdata(imem_wdata[1]), .r0_we(r0_we[1]), .r0_data(r0_data[1]), .fence(fence[1]),
        .prog_valid(prog_valid[1]), .instr_count(instr_count[1]), .err_abort(err_abort[1]));

    core_frame_receiver #(.CORE_ID(4)) u_core4 (
        .clk(clk), .reset(reset), .frame_being_sent(frame_being_sent), .bus_valid(bus_valid),
        .bus_data(bus_data), .exec_done(exec_done), .core_ready(core_ready[2]),
        .core_reading(core_reading[2]), .imem_we(imem_we[2]), .imem_addr(imem_addr[2]),
        .imem_wdata(imem_wdata[2]), .r0_we(r0_we[2]), .r0_data(r0_data[2]), .fence(fence[2]),
        .prog_valid(prog_valid[2]), .instr_count(instr_count[2]), .err_abort(err_abort[2]));

    int checks = 0;
    int failures = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Per-receiver activity statistics gathered on the falling edge
    int          we_cnt      [N];
    int          addr_bad    [N];
    int          data_bad    [N];
    int          exp_addr    [N];
    int          r0_cnt      [N];
    logic [15:0] r0_val      [N];
    int          pv_cnt      [N];
    int          pv_prev_addr[N];
    int          prev_addr   [N];
    int          ready_low   [N];
    int          reading_cnt [N];

    task automatic clear_stats();
        for (int i = 0; i < N; i++) begin
            we_cnt[i] = 0; addr_bad[i] = 0; data_bad[i] = 0; exp_addr[i] = 0;
            r0_cnt[i] = 0; r0_val[i] = 16'h0; pv_cnt[i] = 0; pv_prev_addr[i] = -1;
            prev_addr[i] = -1; ready_low[i] = 0; reading_cnt[i] = 0;
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (imem_we[i]) begin
                if (imem_addr[i] != 6'(exp_addr[i])) addr_bad[i]++;
                if (imem_wdata[i] != 16'hA000 + 16'(exp_addr[i])) data_bad[i]++;
                exp_addr[i]++;
                we_cnt[i]++;
            end
            if (r0_we[i]) begin
                r0_cnt[i]++;
                r0_val[i] = r0_data[i];
            end
            if (prog_valid[i]) begin
                pv_cnt[i]++;
                pv_prev_addr[i] = prev_addr[i];
            end
            if (!core_ready[i]) ready_low[i]++;
            if (core_reading[i]) reading_cnt[i]++;
            prev_addr[i] = imem_we[i] ? int'(imem_addr[i]) : -1;
        end
    end

    int word_no = 0;

    // One bus word, with an idle (bus_valid low) cycle inserted now and then
    task automatic drive_word(input logic [15:0] d);
        @(posedge clk); #1;
        frame_being_sent = 1'b1; bus_valid = 1'b1; bus_data = d;
        word_no++;
        if (word_no % 7 == 3) begin
            @(posedge clk); #1;
            bus_valid = 1'b0; bus_data = 16'hDEAD;
        end
    endtask

    function automatic logic [15:0] hdr_word(input int i, input logic [15:0] w0,
                                             input logic [15:0] w1, input logic [15:0] w2);
        if (i == 0) return w0;
        if (i == 1) return w1;
        if (i == 2) return w2;
        if (i == 8) return 16'hBEEF;
        return 16'h1000 + 16'(i);
    endfunction

    task automatic bus_idle(input int cycles);
        @(posedge clk); #1;
        frame_being_sent = 1'b0; bus_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Header followed by n_instr instruction words (instruction k carries 0xA000+k)
    task automatic send_stream(input logic [15:0] w0, input logic [15:0] w1,
                               input logic [15:0] w2, input int n_instr);
        for (int i = 0; i < 16; i++) drive_word(hdr_word(i, w0, w1, w2));
        for (int k = 0; k < n_instr; k++) drive_word(16'hA000 + 16'(k));
        bus_idle(3);
        $display("stream w0=%04h w1=%04h w2=%04h instr_words=%0d", w0, w1, w2, n_instr);
    endtask

    task automatic pulse_exec_done();
        @(posedge clk); #1; exec_done = 1'b1;
        @(posedge clk); #1; exec_done = 0;
        $display("exec_done pulse");
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        // bus_valid with frame_being_sent low must not start a frame
        bus_valid = 1'b1; bus_data = 16'h0003;
        repeat (3) @(posedge clk);
        #1 bus_valid = 1'b0;
        @(negedge clk);
        check_value("rst_ready", core_ready[0], 1);
        check_value("rst_reading", core_reading[0], 0);
        check_value("rst_pv", prog_valid[0], 0);
        check_value("rst_err", err_abort[0], 0);
        check_value("rst_count", instr_count[0], 0);
        check_value("rst_fence", fence[0], 0);

        // Tests 1-3: two instruction frames; core 0 and 8 selected, core 4 not
        clear_stats();
        send_stream(16'h0002, 16'h0f0f, 16'h0f00, 32);
        @(negedge clk);
        check_value("t1_we_cnt", we_cnt[0], 32);
        check_value("t1_addr_bad", addr_bad[0], 0);
        check_value("t1_data_bad", data_bad[0], 0);
        check_value("t1_r0_cnt", r0_cnt[0], 0);
        check_value("t1_pv_cnt", pv_cnt[0], 1);
        check_value("t1_pv_after31", pv_prev_addr[0], 31);
        check_value("t1_count", instr_count[0], 32);
        check_value("t1_fence", fence[0], 0);
        check_value("t1_ready", core_ready[0], 0);
        check_value("t1_reading", core_reading[0], 0);
        check_value("t1_read_seen", reading_cnt[0] > 0, 1);
        check_value("t2_r0_cnt", r0_cnt[1], 1);
        check_value("t2_r0_val", r0_val[1], 16'hBEEF);
        check_value("t2_we_cnt", we_cnt[1], 32);
        check_value("t2_addr_bad", addr_bad[1], 0);
        check_value("t2_pv_cnt", pv_cnt[1], 1);
        check_value("t3_we_cnt", we_cnt[2], 0);
        check_value("t3_r0_cnt", r0_cnt[2], 0);
        check_value("t3_ready_low", ready_low[2], 0);
        check_value("t3_reading", reading_cnt[2], 0);
        check_value("t3_pv_cnt", pv_cnt[2], 0);

        // Test 5: loaded cores ignore a new stream; core 4 (now selected) takes it
        clear_stats();
        send_stream(16'h0005, 16'h0f1f, 16'h0f10, 16);
        @(negedge clk);
        check_value("t5_ign_we", we_cnt[0], 0);
        check_value("t5_ign_pv", pv_cnt[0], 0);
        check_value("t5_ign_ready", core_ready[0], 0);
        check_value("t5_ign_count", instr_count[0], 32);
        check_value("t5_c4_we", we_cnt[2], 16);
        check_value("t5_c4_pv_after15", pv_prev_addr[2], 15);
        check_value("t5_c4_count", instr_count[2], 16);
        check_value("t5_c4_fence", fence[2], 1);
        check_value("t5_c4_r0", r0_val[2], 16'h100C);
        pulse_exec_done();
        @(negedge clk);
        check_value("t5_ready0", core_ready[0], 1);
        check_value("t5_ready4", core_ready[2], 1);
        clear_stats();
        send_stream(16'h0002, 16'h0f0f, 16'h0f00, 32);
        @(negedge clk);
        check_value("t5_reload_we", we_cnt[0], 32);
        check_value("t5_reload_addr", addr_bad[0], 0);
        check_value("t5_reload_pv", pv_cnt[0], 1);
        check_value("t5_reload_c4_we", we_cnt[2], 0);
        pulse_exec_done();

        // Test 4: frame_being_sent falls after instruction word 5
        clear_stats();
        send_stream(16'h0002, 16'h0f0f, 16'h0f00, 6);
        @(negedge clk);
        check_value("t4_we_cnt", we_cnt[0], 6);
        check_value("t4_addr_bad", addr_bad[0], 0);
        check_value("t4_pv_cnt", pv_cnt[0], 0);
        check_value("t4_err", err_abort[0], 1);
        check_value("t4_ready", core_ready[0], 1);
        check_value("t4_err8", err_abort[1], 1);
        check_value("t4_err4", err_abort[2], 0);

        // Test 6: reset during header word 10, then a clean full load
        clear_stats();
        for (int i = 0; i <= 10; i++) drive_word(hdr_word(i, 16'h0002, 16'h0f0f, 16'h0f00));
        @(posedge clk); #1;
        reset = 1'b1; frame_being_sent = 1'b0; bus_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        $display("reset during header word 10");
        @(negedge clk);
        check_value("t6_rst_err", err_abort[0], 0);
        check_value("t6_rst_ready", core_ready[0], 1);
        check_value("t6_rst_we", we_cnt[0], 0);
        clear_stats();
        send_stream(16'h0002, 16'h0f0f, 16'h0f00, 32);
        @(negedge clk);
        check_value("t6_we_cnt", we_cnt[0], 32);
        check_value("t6_addr_bad", addr_bad[0], 0);
        check_value("t6_pv_after31", pv_prev_addr[0], 31);
        check_value("t6_pv_cnt", pv_cnt[0], 1);
        check_value("t6_count", instr_count[0], 32);
        check_value("t6_err", err_abort[0], 0);
        check_value("t6_ready", core_ready[0], 0);
        check_value("t6_r0_val8", r0_val[1], 16'hBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
